instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 Parameter IMEM_DEPTH, default 256: instruction memory depth in 32-bit words.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 stall  input  1: hold PC and IF/ID register this cycle.
REQ-006 redirect  input  1: branch/jump taken; replace PC with redirect_pc.
REQ-007 redirect_pc  input  32: byte target address, valid when redirect=1.
REQ-008 imem_addr  output  32: word index to instruction memory, equal to {2'b00, pc[31:2]}.
REQ-009 imem_instr  input  32: instruction word, combinationally returned for imem_addr in the same cycle.
REQ-010 if_id_valid  output  1: IF/ID register holds a real instruction.
REQ-011 if_id_pc  output  32: byte PC of the instruction in IF/ID.
REQ-012 if_id_pc4  output  32: if_id_pc + 4.
REQ-013 if_id_instr  output  32: instruction in IF/ID.
REQ-014 fetch_fault  output  1: sticky; misaligned or out-of-range fetch detected.

Function
REQ-015 The block SHALL implement the FSM states BOOT, RUN and HALT.
REQ-016 BOOT SHALL last exactly one cycle after rst deasserts, issue imem_addr for RESET_PC, load IF/ID on the following edge, and go to RUN.
REQ-017 In RUN, every non-stalled, non-redirected edge SHALL load IF/ID with {valid=1, pc, pc+4, imem_instr} and set pc <= pc + 4, so fetch-to-IF/ID latency is one cycle.
REQ-018 Priority SHALL be rst > redirect > stall > normal advance.
REQ-019 On redirect, the block SHALL set pc <= redirect_pc and if_id_valid <= 0, with if_id_instr <= 32'h0000_0013 (NOP), giving exactly one bubble.
REQ-020 Redirect asserted together with stall SHALL be honoured; the stall is ignored that cycle.
REQ-021 On stall without redirect, pc and all IF/ID fields SHALL hold their values.
REQ-022 A redirect_pc with bits [1:0] != 0 SHALL set fetch_fault=1, capture the target in pc, clear if_id_valid, and move to HALT.
REQ-023 A pc with pc[31:2] >= IMEM_DEPTH in RUN SHALL be treated the same as REQ-022, before any IF/ID load.
REQ-024 In HALT, pc, fetch_fault and if_id_valid=0 SHALL hold; only rst exits HALT.
REQ-025 pc + 4 SHALL be 32-bit modulo; wrap-around is reachable only when IMEM_DEPTH covers the full space.
REQ-026 imem_addr SHALL be driven from the pc register only, never combinationally from redirect inputs.

Reset
REQ-027 While rst=1 at an edge: pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=32'h0000_0013, fetch_fault=0.
REQ-028 rst asserted mid-operation, including during stall, redirect or HALT, SHALL take effect on that edge and discard in-flight state.

Structure
REQ-029 A shared package rv32_pkg SHALL hold NOP_INSTR (32'h0000_0013), the fetch_state_t enum {BOOT, RUN, HALT} and XLEN=32.
REQ-030 The IF/ID register (valid, pc, pc4, instr with load/hold/bubble control) SHALL be a sub-module named if_id_reg; PC logic and the FSM SHALL stay in instr_fetch.

Verification
REQ-031 Bench SHALL cover: memory words 0..2 = 0x00200513, 0x00100113, 0x00250233, reset then run 4 cycles -> imem_addr 0,1,2,3; if_id_instr 0x00200513, 0x00100113, 0x00250233 with if_id_pc 0x0, 0x4, 0x8.
REQ-032 Bench SHALL cover: redirect=1, redirect_pc=0x20 while pc=0x8 -> next if_id_valid=0 with NOP; next imem_addr=8; following if_id_pc=0x20.
REQ-033 Bench SHALL cover: stall=1 for 3 cycles at pc=0x4 -> imem_addr stays 1 and if_id_* unchanged; advance resumes the cycle after stall drops.
REQ-034 Bench SHALL cover: stall=1 and redirect=1 with redirect_pc=0x10 in the same cycle -> pc=0x10 and if_id_valid=0.
REQ-035 Bench SHALL cover: redirect_pc=0x6 -> fetch_fault=1, state HALT, pc=0x6 held for 5 cycles; then rst -> pc=RESET_PC and fault cleared.
REQ-036 Bench SHALL cover: IMEM_DEPTH=4, run from 0 -> at pc=0x10, fetch_fault=1, no IF/ID load for word 4, HALT.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the front end: datapath width, the canonical
// NOP encoding and the fetch controller state type.
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : rv32_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble overrides load: it clears valid and puts a
// NOP in the instruction slot, leaving the PC fields untouched. With neither
// control asserted every field holds.
module if_id_reg
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc4_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Next-value selection: bubble, load or hold.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can leave one
    // unassigned and infer a latch.
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      pc4_d   = pc4_in;
      instr_d = instr_in;
    end
  end

  // State register with synchronous reset to an empty NOP slot.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;
  assign instr = instr_q;

endmodule : if_id_reg

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT controller and the
// IF/ID register. The instruction memory answers combinationally, so the
// word fetched in one cycle lands in IF/ID on the next edge. A misaligned
// redirect target or a PC beyond the memory parks the stage in HALT with a
// sticky fault until reset.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault
);

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(IMEM_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            ifid_load;
  logic            ifid_bubble;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] word_idx;
  logic            pc_out_of_range;

  // Memory is word addressed and sourced from the PC register only.
  assign word_idx        = {2'b00, pc_q[XLEN-1:2]};
  assign imem_addr       = word_idx;
  assign pc_out_of_range = (word_idx >= DEPTH_W);
  assign pc_plus4        = pc_q + 32'd4;

  // Controller: redirect beats the range check, which beats stall, which
  // beats normal advance. BOOT behaves like RUN for one cycle and then
  // always hands over to RUN (or HALT on a fault).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      BOOT, RUN: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end else if (pc_out_of_range) begin
          fault_d     = 1'b1;
          ifid_bubble = 1'b1;
          state_d     = HALT;
        end else if (stall) begin
          state_d = RUN;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = RUN;
        end
      end
      HALT: begin
        // Everything holds; only reset leaves this state.
      end
      default: begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  // PC, state and fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .pc_in    (pc_q),
    .pc4_in   (pc_plus4),
    .instr_in (imem_instr),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .pc4      (if_id_pc4),
    .instr    (if_id_instr)
  );

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Each step drives inputs, pushes the
// expected post-edge state onto a scoreboard, then pops and compares one
// nanosecond after the rising edge. A second instance with a four-word
// memory exercises the out-of-range fault.
module tb_instr_fetch;
  import rv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (IMEM_DEPTH = 256)
  logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_instr, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, fetch_fault;

  // Small instance (IMEM_DEPTH = 4)
  logic        rst4 = 1'b1;
  logic        stall4 = 1'b0, redirect4 = 1'b0;
  logic [31:0] redirect_pc4 = '0;
  logic [31:0] imem_addr4, imem_instr4, if_id_pc_4, if_id_pc4_4, if_id_instr_4;
  logic        if_id_valid_4, fetch_fault_4;

  logic [31:0] mem [0:255];

  assign imem_instr  = (imem_addr  < 32'd256) ? mem[imem_addr[7:0]]  : 32'hDEAD_BEEF;
  assign imem_instr4 = (imem_addr4 < 32'd256) ? mem[imem_addr4[7:0]] : 32'hDEAD_BEEF;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .fetch_fault(fetch_fault)
  );

  instr_fetch #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .stall(stall4), .redirect(redirect4),
    .redirect_pc(redirect_pc4), .imem_addr(imem_addr4), .imem_instr(imem_instr4),
    .if_id_valid(if_id_valid_4), .if_id_pc(if_id_pc_4), .if_id_pc4(if_id_pc4_4),
    .if_id_instr(if_id_instr_4), .fetch_fault(fetch_fault_4)
  );

  typedef struct {
    string       tag;
    bit          sel;        // 0: main instance, 1: small instance
    logic [31:0] addr;
    logic        fault;
    logic        valid;
    bit          chk_pc;
    logic [31:0] pc;
    logic [31:0] pc4;
    bit          chk_instr;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t e_reset(input string tag, input bit sel);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = 32'd0; e.fault = 1'b0; e.valid = 1'b0;
    e.chk_pc = 1'b1; e.pc = 32'd0; e.pc4 = 32'd0;
    e.chk_instr = 1'b1; e.instr = NOP_INSTR;
    return e;
  endfunction

  function automatic exp_t e_load(input string tag, input bit sel, input logic [31:0] addr,
                                  input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.fault = 1'b0; e.valid = 1'b1;
    e.chk_pc = 1'b1; e.pc = pc; e.pc4 = pc + 32'd4;
    e.chk_instr = 1'b1; e.instr = instr;
    return e;
  endfunction

  function automatic exp_t e_bubble(input string tag, input bit sel, input logic [31:0] addr,
                                    input logic fault);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.fault = fault; e.valid = 1'b0;
    e.chk_pc = 1'b0; e.pc = '0; e.pc4 = '0;
    e.chk_instr = 1'b1; e.instr = NOP_INSTR;
    return e;
  endfunction

  task automatic check_front();
    exp_t        e;
    logic [31:0] a, p, p4, ins;
    logic        v, f;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      a = imem_addr4; p = if_id_pc_4; p4 = if_id_pc4_4; ins = if_id_instr_4;
      v = if_id_valid_4; f = fetch_fault_4;
    end else begin
      a = imem_addr; p = if_id_pc; p4 = if_id_pc4; ins = if_id_instr;
      v = if_id_valid; f = fetch_fault;
    end
    chk({e.tag, ".imem_addr"}, a, e.addr);
    chk({e.tag, ".fault"}, 32'(f), 32'(e.fault));
    chk({e.tag, ".valid"}, 32'(v), 32'(e.valid));
    if (e.chk_pc) begin
      chk({e.tag, ".if_id_pc"}, p, e.pc);
      chk({e.tag, ".if_id_pc4"}, p4, e.pc4);
    end
    if (e.chk_instr) chk({e.tag, ".if_id_instr"}, ins, e.instr);
  endtask

  // One clock of the main instance.
  task automatic step(input logic s, input logic r, input logic [31:0] rp, input exp_t e);
    stall = s; redirect = r; redirect_pc = rp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  // One clock of the small instance.
  task automatic step4(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    exp_t e;
    mem[0] = 32'h0020_0513;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0025_0233;
    for (int i = 3; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);

    // Straight-line fetch after reset.
    rst = 1'b1;
    step(0, 0, 0, e_reset("rstA", 0));
    rst = 1'b0;
    step(0, 0, 0, e_load("runA0", 0, 32'd1, 32'h0, 32'h0020_0513));
    step(0, 0, 0, e_load("runA1", 0, 32'd2, 32'h4, 32'h0010_0113));
    step(0, 0, 0, e_load("runA2", 0, 32'd3, 32'h8, 32'h0025_0233));

    // Stall at pc=0x4, then a redirect at pc=0x8.
    rst = 1'b1;
    step(0, 0, 0, e_reset("rstB", 0));
    rst = 1'b0;
    step(0, 0, 0, e_load("bootB", 0, 32'd1, 32'h0, mem[0]));
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, e_load($sformatf("stall%0d", i), 0, 32'd1, 32'h0, mem[0]));
    step(0, 0, 0, e_load("resume", 0, 32'd2, 32'h4, mem[1]));
    step(0, 1, 32'h20, e_bubble("redir", 0, 32'd8, 1'b0));
    step(0, 0, 0, e_load("after_redir", 0, 32'd9, 32'h20, mem[8]));

    // Redirect together with stall: the redirect wins.
    step(1, 1, 32'h10, e_bubble("stall_redir", 0, 32'd4, 1'b0));
    step(0, 0, 0, e_load("after_sr", 0, 32'd5, 32'h10, mem[4]));

    // Misaligned target: fault, HALT holds against any input.
    step(0, 1, 32'h6, e_bubble("misalign", 0, 32'd1, 1'b1));
    step(0, 0, 0,     e_bubble("halt0", 0, 32'd1, 1'b1));
    step(1, 0, 0,     e_bubble("halt1", 0, 32'd1, 1'b1));
    step(0, 1, 32'h40, e_bubble("halt2", 0, 32'd1, 1'b1));
    step(1, 1, 32'h8, e_bubble("halt3", 0, 32'd1, 1'b1));
    step(0, 0, 0,     e_bubble("halt4", 0, 32'd1, 1'b1));

    // Reset out of HALT while stall and redirect are also asserted.
    rst = 1'b1;
    step(1, 1, 32'h44, e_reset("rstC", 0));
    rst = 1'b0;
    step(0, 0, 0, e_load("bootC", 0, 32'd1, 32'h0, mem[0]));

    // Four-word memory: word 4 must fault instead of loading.
    rst = 1'b1;
    rst4 = 1'b1;
    step4(e_reset("rst4", 1));
    rst4 = 1'b0;
    step4(e_load("d4_0", 1, 32'd1, 32'h0, mem[0]));
    step4(e_load("d4_1", 1, 32'd2, 32'h4, mem[1]));
    step4(e_load("d4_2", 1, 32'd3, 32'h8, mem[2]));
    step4(e_load("d4_3", 1, 32'd4, 32'hC, mem[3]));
    e = e_bubble("d4_oor", 1, 32'd4, 1'b1);
    e.chk_pc = 1'b1; e.pc = 32'hC; e.pc4 = 32'h10;
    e.chk_instr = 1'b0;
    step4(e);
    e.tag = "d4_halt";
    step4(e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
